// File: rtl/abrir_barreira.sv
// abrir_barreira: timed barrier opener with vehicle-presence hold
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous active-high reset
//   pedido   - open request, accepted only while closed
//   sensor   - vehicle under barrier, restarts the open countdown
//   terminar - open duration in seconds, latched on acceptance (0 means 1)
//   tempo    - seconds elapsed in current open period
//   abrir    - barrier commanded open
//   ocupado  - request in progress
//   fim      - one-cycle pulse at end of open period
module abrir_barreira #(
   parameter int TICKS_SEG = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pedido,
   input  logic       sensor,
   input  logic [6:0] terminar,
   output logic [6:0] tempo,
   output logic       abrir,
   output logic       ocupado,
   output logic       fim
);
   localparam int W = $clog2(TICKS_SEG);
   typedef enum logic [1:0] {FECHADA = 2'd0, ABERTA = 2'd1, FECHO = 2'd2} state_t;
   state_t state;
   logic [6:0] limite;
   logic [W-1:0] presc;
   logic tick;
   assign tick = presc == W'(TICKS_SEG - 1);
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= FECHADA;
         tempo   <= '0;
         limite  <= '0;
         presc   <= '0;
         abrir   <= 1'b0;
         ocupado <= 1'b0;
         fim     <= 1'b0;
      end else begin
         case (state)
            FECHADA: begin
               fim   <= 1'b0;
               tempo <= '0;
               if (pedido) begin
                  state   <= ABERTA;
                  limite  <= terminar == '0 ? 7'd1 : terminar;
                  presc   <= '0;
                  abrir   <= 1'b1;
                  ocupado <= 1'b1;
               end
            end
            ABERTA: begin
               // a present vehicle restarts the whole countdown
               if (sensor) begin
                  tempo <= '0;
                  presc <= '0;
               end else if (tick) begin
                  presc <= '0;
                  tempo <= tempo + 7'd1;
                  if (tempo + 7'd1 == limite) begin
                     state   <= FECHO;
                     abrir   <= 1'b0;
                     ocupado <= 1'b0;
                     fim     <= 1'b1;
                  end
               end else begin
                  presc <= presc + W'(1);
               end
            end
            FECHO: begin
               state <= FECHADA;
               fim   <= 1'b0;
               tempo <= '0;
            end
            default: begin
               state   <= FECHADA;
               tempo   <= '0;
               presc   <= '0;
               abrir   <= 1'b0;
               ocupado <= 1'b0;
               fim     <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_abrir_barreira.sv
// tb_abrir_barreira: directed self-checking bench for abrir_barreira
module tb_abrir_barreira;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic pedido = 1'b0;
   logic sensor = 1'b0;
   logic [6:0] terminar = 7'd0;
   logic [6:0] tempo;
   logic abrir, ocupado, fim;
   int n_chk = 0;
   int n_pass = 0;
   int n_abr, n_fim, t_fim;
   abrir_barreira #(.TICKS_SEG(4)) dut (
      .clock(clock), .reset(reset), .pedido(pedido), .sensor(sensor),
      .terminar(terminar), .tempo(tempo), .abrir(abrir), .ocupado(ocupado), .fim(fim)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      else n_pass++;
   endtask
   task automatic tick_clk();
      @(posedge clock);
      #1;
   endtask
   task automatic watch(input int n);
      n_abr = 0;
      n_fim = 0;
      t_fim = -1;
      for (int i = 0; i < n; i++) begin
         if (abrir) n_abr++;
         if (fim) begin
            n_fim++;
            t_fim = int'(tempo);
         end
         tick_clk();
      end
   endtask
   task automatic accept(input logic [6:0] t);
      terminar = t;
      pedido = 1'b1;
      tick_clk();
      pedido = 1'b0;
   endtask
   initial begin
      tick_clk();
      tick_clk();
      check("rst_abrir", int'(abrir), 0);
      check("rst_ocupado", int'(ocupado), 0);
      check("rst_fim", int'(fim), 0);
      check("rst_tempo", int'(tempo), 0);
      reset = 1'b0;
      tick_clk();
      check("idle_abrir", int'(abrir), 0);
      // three-second period, tempo steps every four cycles
      accept(7'd3);
      for (int i = 1; i <= 12; i++) begin
         check($sformatf("t3_abrir_%0d", i), int'(abrir), 1);
         check($sformatf("t3_ocupado_%0d", i), int'(ocupado), 1);
         check($sformatf("t3_tempo_%0d", i), int'(tempo), (i - 1) / 4);
         check($sformatf("t3_fim_%0d", i), int'(fim), 0);
         tick_clk();
      end
      check("t3_fecho_abrir", int'(abrir), 0);
      check("t3_fecho_ocupado", int'(ocupado), 0);
      check("t3_fecho_fim", int'(fim), 1);
      check("t3_fecho_tempo", int'(tempo), 3);
      tick_clk();
      check("t3_after_fim", int'(fim), 0);
      check("t3_after_tempo", int'(tempo), 0);
      // zero duration behaves as one second
      accept(7'd0);
      watch(20);
      check("t0_open", n_abr, 4);
      check("t0_fims", n_fim, 1);
      check("t0_tempo_fim", t_fim, 1);
      // vehicle present restarts the countdown
      accept(7'd2);
      repeat (4) tick_clk();
      check("sens_tempo_before", int'(tempo), 1);
      sensor = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick_clk();
         check($sformatf("sens_tempo_%0d", i), int'(tempo), 0);
         check($sformatf("sens_abrir_%0d", i), int'(abrir), 1);
      end
      sensor = 1'b0;
      watch(20);
      check("sens_open", n_abr, 8);
      check("sens_fims", n_fim, 1);
      check("sens_tempo_fim", t_fim, 2);
      // held request: 8 open, FECHO, FECHADA, repeat
      terminar = 7'd2;
      pedido = 1'b1;
      tick_clk();
      for (int i = 0; i < 30; i++) begin
         check($sformatf("hold_abrir_%0d", i), int'(abrir), (i % 10) < 8 ? 1 : 0);
         check($sformatf("hold_fim_%0d", i), int'(fim), (i % 10) == 8 ? 1 : 0);
         tick_clk();
      end
      pedido = 1'b0;
      watch(20);
      check("hold_drain_fims", n_fim, 1);
      check("hold_drain_abrir", int'(abrir), 0);
      // reset mid-operation beats a pending request
      accept(7'd5);
      repeat (8) tick_clk();
      check("rst_mid_tempo_before", int'(tempo), 2);
      reset = 1'b1;
      pedido = 1'b1;
      tick_clk();
      check("rst_mid_abrir", int'(abrir), 0);
      check("rst_mid_tempo", int'(tempo), 0);
      check("rst_mid_ocupado", int'(ocupado), 0);
      check("rst_mid_fim", int'(fim), 0);
      reset = 1'b0;
      accept(7'd1);
      watch(12);
      check("rst_after_open", n_abr, 4);
      check("rst_after_fims", n_fim, 1);
      // duration change after acceptance is ignored
      accept(7'd2);
      terminar = 7'd9;
      watch(20);
      check("chg_open", n_abr, 8);
      check("chg_tempo_fim", t_fim, 2);
      check("chg_fims", n_fim, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/abrir_barreira.md
ABRIR_BARREIRA -- requirements
Module: abrir_barreira

Interface
REQ-001 Parameter TICKS_SEG, default 50000000, number of Clock cycles per one-second tick; legal range 2 to 2^26.
REQ-002 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 Pedido  input  1  open request; level-sampled each cycle.
REQ-005 Sensor  input  1  vehicle present under barrier; level-sampled each cycle.
REQ-006 Terminar  input  7  open duration in seconds; sampled only when a request is accepted.
REQ-007 Tempo  output  7  seconds elapsed in the current open period, registered.
REQ-008 Abrir  output  1  1 = barrier commanded open, registered.
REQ-009 Ocupado  output  1  1 = request in progress, new Pedido ignored, registered.
REQ-010 Fim  output  1  one-cycle pulse marking end of an open period, registered.

Function
REQ-011 FSM states SHALL be FECHADA, ABERTA and FECHO, encoded in 2 bits, with unused encodings returning to FECHADA on the next edge.
REQ-012 In FECHADA, Pedido=1 at an edge SHALL move to ABERTA, latch Limite = Terminar (Terminar=0 latched as 1), clear Tempo and the prescaler.
REQ-013 Abrir and Ocupado SHALL be 1 in exactly the cycles where state is ABERTA; they SHALL be 0 in FECHADA and FECHO.
REQ-014 The prescaler SHALL count 0..TICKS_SEG-1 only in ABERTA; the tick is the cycle in which it equals TICKS_SEG-1, after which it wraps to 0.
REQ-015 On a tick with Sensor=0, Tempo SHALL increment by 1; first increment occurs TICKS_SEG cycles after entry into ABERTA.
REQ-016 In ABERTA, Sensor=1 SHALL clear Tempo and the prescaler on that edge, so the full Limite restarts after Sensor falls; Sensor takes priority over a tick.
REQ-017 When a tick with Sensor=0 makes Tempo equal Limite, the state SHALL move to FECHO on that same edge (Tempo shows Limite in FECHO).
REQ-018 FECHO SHALL last exactly one cycle with Fim=1, then go to FECHADA clearing Tempo to 0; Fim SHALL be 0 in all other cycles.
REQ-019 Pedido in ABERTA or FECHO SHALL be ignored (no restart, no queueing); Pedido held high through FECHO SHALL be accepted in FECHADA on the following edge.
REQ-020 Changes of Terminar after acceptance SHALL NOT affect the current open period.
REQ-021 Tempo SHALL never exceed Limite; no arithmetic wrap is possible since Limite <= 127.
REQ-022 Total open time with Sensor=0 SHALL be Limite*TICKS_SEG cycles of Abrir=1.

Reset
REQ-023 Reset=1 SHALL force state FECHADA, Tempo=0, Limite=0, prescaler=0, Abrir=0, Ocupado=0, Fim=0 on the next edge, from any state.
REQ-024 Reset SHALL take priority over Pedido, Sensor and ticks in the same cycle; no Fim pulse is produced by a reset mid-operation.
REQ-025 After Reset falls, the first Pedido SHALL be accepted on the first edge at which Reset=0 and Pedido=1.

Verification (TICKS_SEG=4)
REQ-026 Terminar=3, Pedido pulse 1 cycle, Sensor=0 -> Abrir=1 for 12 cycles, Tempo 0,1,2 stepping every 4 cycles, then FECHO with Tempo=3, Fim=1 for 1 cycle, then Tempo=0.
REQ-027 Terminar=0, Pedido pulse -> Abrir=1 for 4 cycles, Tempo reaches 1, Fim pulse once.
REQ-028 Terminar=2, Sensor=1 for 6 cycles starting when Tempo=1 -> Tempo held 0 during Sensor, then Abrir stays 1 for 8 more cycles before Fim.
REQ-029 Terminar=2, Pedido held high continuously -> open periods of 8 cycles separated by exactly 2 cycles of Abrir=0 (FECHO, FECHADA), Fim once per period.
REQ-030 Terminar=5, Reset=1 asserted when Tempo=2 -> next edge: Abrir=0, Tempo=0, Ocupado=0, no Fim; subsequent Pedido with Terminar=1 opens for 4 cycles.
REQ-031 Terminar changed from 2 to 9 while Abrir=1 -> period still ends after 8 cycles with Tempo=2 at Fim.
